// File: rtl/dp_pkg.sv
// rtl/dp_pkg.sv - shared types for the shift-datapath sequencer
package dp_pkg;

  typedef enum logic [1:0] {
    FN_HOLD = 2'b00,
    FN_SHR  = 2'b01,
    FN_SHL  = 2'b10,
    FN_ROT  = 2'b11
  } func_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    LOAD  = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } seq_state_e;

  function automatic func_e dir_func(input logic dir);
    return dir ? FN_SHL : FN_SHR;
  endfunction

endpackage

// File: rtl/dp_tick_gen.sv
// rtl/dp_tick_gen.sv - prescaler producing one tick every TICK_DIV enabled clocks
module dp_tick_gen #(
  parameter int TICK_DIV = 600
) (
  input  logic clk,
  input  logic clr_n,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  // Dropping en restarts the count so the next enabled step is a full one.
  always_ff @(posedge clk) begin
    if (!clr_n || !en) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/dp_seq_ctrl.sv
// rtl/dp_seq_ctrl.sv - CLEAR/LOAD/SHIFTxN sequencer for the 8-bit shift datapath
// Optional rotate support via DP_ROTATE_EN.
module dp_seq_ctrl
  import dp_pkg::*;
#(
  parameter int TICK_DIV = 600,
  parameter int CNT_W    = 3
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic             abort,
  input  logic             src_sel,
  input  logic             dir,
  input  logic             rot,
  input  logic [CNT_W-1:0] count,
  output logic             sel1,
  output logic             sel2,
  output func_e            func,
  output logic             dp_clr,
  output logic             dp_load,
  output logic             busy,
  output logic             done
);

  seq_state_e       state;
  logic             src_q;
  logic             dir_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] rem;
  logic             run;
  logic             tick;
  func_e            shift_fn;

  assign run = (state == CLEAR) || (state == LOAD) || (state == SHIFT);

  dp_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .clr_n(clr_n),
    .en   (run && !abort),
    .tick (tick)
  );

`ifdef DP_ROTATE_EN
  logic rot_q;

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      rot_q <= 1'b0;
    end else if (state == IDLE && start && !abort) begin
      rot_q <= rot;
    end
  end

  assign shift_fn = rot_q ? FN_ROT : dir_func(dir_q);
`else
  logic unused_rot;
  assign unused_rot = rot;
  assign shift_fn   = dir_func(dir_q);
`endif

  // Outputs are a registered decode of the state held during the previous
  // clock, so each control stays constant for the whole step it belongs to.
  always_ff @(posedge clk) begin
    if (!clr_n || abort) begin
      state   <= IDLE;
      sel1    <= 1'b0;
      sel2    <= 1'b0;
      func    <= FN_HOLD;
      dp_clr  <= 1'b0;
      dp_load <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      if (!clr_n) begin
        src_q <= 1'b0;
        dir_q <= 1'b0;
        cnt_q <= '0;
        rem   <= '0;
      end
    end else begin
      sel1    <= 1'b0;
      sel2    <= 1'b0;
      func    <= FN_HOLD;
      dp_clr  <= 1'b0;
      dp_load <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            src_q <= src_sel;
            dir_q <= dir;
            cnt_q <= count;
            state <= CLEAR;
          end
        end
        CLEAR: begin
          dp_clr <= 1'b1;
          busy   <= 1'b1;
          if (tick) state <= LOAD;
        end
        LOAD: begin
          sel1    <= src_q;
          dp_load <= 1'b0;
          busy    <= 1'b1;
          if (tick) begin
            if (cnt_q == '0) begin
              state <= DONE;
            end else begin
              rem   <= cnt_q;
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          sel1    <= src_q;
          sel2    <= 1'b1;
          func    <= shift_fn;
          dp_load <= 1'b0;
          busy    <= 1'b1;
          if (tick) begin
            if (rem != '0) rem <= rem - CNT_W'(1);
            if (rem == CNT_W'(1)) state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dp_seq_ctrl.sv
// tb/tb_dp_seq_ctrl.sv - scoreboard bench for dp_seq_ctrl (TICK_DIV=4, CNT_W=3)
module tb_dp_seq_ctrl;
  import dp_pkg::*;

  localparam int TD = 4;
  localparam int CW = 3;
  // {sel1, sel2, func[1:0], dp_clr, dp_load, busy, done}
  localparam logic [7:0] V_IDLE  = 8'b0000_0100;
  localparam logic [7:0] V_CLEAR = 8'b0000_1110;
  localparam logic [7:0] V_DONE  = 8'b0000_0101;

  logic          clk = 1'b0;
  logic          clr_n, start, abort, src_sel, dir, rot;
  logic [CW-1:0] count;
  logic          sel1, sel2, dp_clr, dp_load, busy, done;
  func_e         func;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  dp_seq_ctrl #(.TICK_DIV(TD), .CNT_W(CW)) dut (
    .clk(clk), .clr_n(clr_n), .start(start), .abort(abort), .src_sel(src_sel),
    .dir(dir), .rot(rot), .count(count), .sel1(sel1), .sel2(sel2), .func(func),
    .dp_clr(dp_clr), .dp_load(dp_load), .busy(busy), .done(done)
  );

  function automatic logic [7:0] obs();
    return {sel1, sel2, func, dp_clr, dp_load, busy, done};
  endfunction

  // Expected per-clock outputs, starting with the sample right after the accept edge.
  task automatic push_cmd(input logic s, input logic d, input logic r, input int n);
    logic [1:0] f;
`ifdef DP_ROTATE_EN
    f = r ? 2'b11 : (d ? 2'b10 : 2'b01);
`else
    f = d ? 2'b10 : 2'b01;
`endif
    exp_q.push_back(V_IDLE);
    for (int i = 0; i < TD; i++) exp_q.push_back(V_CLEAR);
    for (int i = 0; i < TD; i++) exp_q.push_back({s, 7'b000_0010});
    for (int i = 0; i < n * TD; i++) exp_q.push_back({s, 1'b1, f, 4'b0010});
    exp_q.push_back(V_DONE);
    exp_q.push_back(V_IDLE);
  endtask

  task automatic test_reset();
    clr_n = 1'b0; start = 1'b1; abort = 1'b0;
    src_sel = 1'b1; dir = 1'b1; rot = 1'b0; count = 3'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if (obs() !== V_IDLE) begin
        tests_failed++;
        $display("FAIL reset_%0d got=%b exp=%b", i, obs(), V_IDLE);
      end
    end
    start = 1'b0;
    clr_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests_run++;
      if (obs() !== V_IDLE) begin
        tests_failed++;
        $display("FAIL reset_release_%0d got=%b exp=%b", i, obs(), V_IDLE);
      end
    end
  endtask

  task automatic test_cmd(input string name, input logic s, input logic d, input logic r,
                          input int n);
    int k = 0;
    int done_at = -1;
    logic [7:0] e;
    src_sel = s; dir = d; rot = r; count = CW'(n); start = 1'b1;
    push_cmd(s, d, r, n);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      start = 1'b0;
      e = exp_q.pop_front();
      tests_run++;
      if (obs() !== e) begin
        tests_failed++;
        $display("FAIL %s_k%0d got=%b exp=%b", name, k, obs(), e);
      end
      if (done === 1'b1 && done_at < 0) done_at = k;
      k++;
    end
    tests_run++;
    if (done_at !== (2 + n) * TD + 1) begin
      tests_failed++;
      $display("FAIL %s_latency got=%0d exp=%0d", name, done_at, (2 + n) * TD + 1);
    end
  endtask

  task automatic test_abort();
    int k = 0;
    int done_at = -1;
    logic [7:0] e;
    src_sel = 1'b1; dir = 1'b0; rot = 1'b0; count = 3'd3; start = 1'b1;
    push_cmd(1'b1, 1'b0, 1'b0, 3);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      start = 1'b0;
      e = exp_q.pop_front();
      tests_run++;
      if (obs() !== e) begin
        tests_failed++;
        $display("FAIL abort_pre_k%0d got=%b exp=%b", i, obs(), e);
      end
    end
    exp_q.delete();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    tests_run++;
    if (obs() !== V_IDLE) begin
      tests_failed++;
      $display("FAIL abort_idle got=%b exp=%b", obs(), V_IDLE);
    end
    src_sel = 1'b0; dir = 1'b1; count = 3'd1; start = 1'b1;
    push_cmd(1'b0, 1'b1, 1'b0, 1);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      start = 1'b0;
      e = exp_q.pop_front();
      tests_run++;
      if (obs() !== e) begin
        tests_failed++;
        $display("FAIL abort_restart_k%0d got=%b exp=%b", k, obs(), e);
      end
      if (done === 1'b1 && done_at < 0) done_at = k;
      k++;
    end
    tests_run++;
    if (done_at !== 3 * TD + 1) begin
      tests_failed++;
      $display("FAIL abort_restart_latency got=%0d exp=%0d", done_at, 3 * TD + 1);
    end
  endtask

  task automatic test_busy_ignore();
    int k = 0;
    int done_at = -1;
    logic [7:0] e;
    src_sel = 1'b1; dir = 1'b1; rot = 1'b0; count = 3'd3; start = 1'b1;
    push_cmd(1'b1, 1'b1, 1'b0, 3);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      start = 1'b0;
      e = exp_q.pop_front();
      tests_run++;
      if (obs() !== e) begin
        tests_failed++;
        $display("FAIL busy_ignore_k%0d got=%b exp=%b", k, obs(), e);
      end
      if (done === 1'b1 && done_at < 0) done_at = k;
      if (k == 3 || k == 10) start = 1'b1;
      if (k == 5) begin
        count = 3'd0; dir = 1'b0; src_sel = 1'b0;
      end
      if (k == 12) begin
        count = 3'd7; dir = 1'b1;
      end
      k++;
    end
    tests_run++;
    if (done_at !== 5 * TD + 1) begin
      tests_failed++;
      $display("FAIL busy_ignore_latency got=%0d exp=%0d", done_at, 5 * TD + 1);
    end
  endtask

  initial begin
    test_reset();
    test_cmd("basic", 1'b1, 1'b1, 1'b0, 3);
    test_cmd("zero_count", 1'b0, 1'b0, 1'b0, 0);
    test_abort();
    test_busy_ignore();
    test_cmd("rotate", 1'b0, 1'b1, 1'b1, 2);
    test_cmd("max_count", 1'b0, 1'b0, 1'b0, 7);
    test_cmd("back_to_back", 1'b1, 1'b0, 1'b0, 1);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
